// File: rtl/li_rr_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : li_rr_merge                                                   |
// | Brief    : N-to-1 latency-insensitive round-robin merge. One registered  |
// |            output slot with valid/backpressure handshakes on both sides. |
// |            It sustains one token per cycle when q_bp stays low.          |
// | Option   : RR_MERGE_LOCK_EN adds d_last and packet locking. A granted    |
// |            channel keeps the slot until it sends its last token.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module li_rr_merge #(
  parameter int Width     = 8,
  parameter int NumInputs = 2,
  parameter int SelWidth  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NumInputs*Width-1:0]  d,
  input  logic [NumInputs-1:0]        d_valid,
`ifdef RR_MERGE_LOCK_EN
  input  logic [NumInputs-1:0]        d_last,
`endif
  output logic [NumInputs-1:0]        d_bp,
  output logic [Width-1:0]            q,
  output logic [SelWidth-1:0]         q_src,
  output logic                        q_valid,
  input  logic                        q_bp
);

  localparam int unsigned c_num_u = NumInputs;

  // Output slot and priority pointer
  logic [Width-1:0]     q_q,     q_d;
  logic [SelWidth-1:0]  src_q,   src_d;
  logic                 valid_q, valid_d;
  logic [SelWidth-1:0]  ptr_q,   ptr_d;

  // Handshake and grant signals
  logic                 load;
  logic [NumInputs-1:0] elig;
  logic [NumInputs-1:0] rot;
  logic                 gnt_any;
  logic [SelWidth-1:0]  gnt_idx;
  logic [NumInputs-1:0] gnt_oh;
  logic [Width-1:0]     gnt_data;
  logic                 gnt_last;

  // Adds an offset to a channel index and wraps it modulo NumInputs
  function automatic logic [SelWidth-1:0] wrap_add(
    input logic [SelWidth-1:0] base,
    input int unsigned         off
  );
    int unsigned s;
    s = {{(32-SelWidth){1'b0}}, base} + off;
    if (s >= c_num_u) begin
      s = s - c_num_u;
    end
    return s[SelWidth-1:0];
  endfunction

  // The slot can take a token when it is empty or drains this cycle
  assign load = ~valid_q | ~q_bp;

`ifdef RR_MERGE_LOCK_EN
  typedef enum logic [0:0] {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

  lock_state_e         lock_q,    lock_d;
  logic [SelWidth-1:0] lock_ch_q, lock_ch_d;

  // While a packet is open, only the owning channel may compete
  always_comb begin
    elig = d_valid;
    if (lock_q == LK_HELD) begin
      for (int i = 0; i < NumInputs; i++) begin
        if (lock_ch_q != SelWidth'(i)) begin
          elig[i] = 1'b0;
        end
      end
    end
  end

  // The winner's end-of-packet marker decides whether the lock closes
  always_comb begin
    gnt_last = |(d_last & gnt_oh);
  end

  // The lock opens on a non-last accept and closes on the last accept
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (load && gnt_any) begin
      if (gnt_last) begin
        lock_d = LK_OPEN;
      end else begin
        lock_d    = LK_HELD;
        lock_ch_d = gnt_idx;
      end
    end
  end

  // Lock state register; reset drops any open packet
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= LK_OPEN;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  // Without packet locking every valid channel competes, and each token closes its own packet
  assign elig     = d_valid;
  assign gnt_last = 1'b1;
`endif

  // Rotate eligible requests so the pointer channel is at bit 0, then take the first set bit
  always_comb begin
    rot     = NumInputs'({elig, elig} >> ptr_q);
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Scan downwards, so the lowest rotated position (closest to ptr) is written last and wins
    for (int k = NumInputs - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(ptr_q, unsigned'(k));
      end
    end
  end

  // Decode the winner into a one-hot vector and select its data
  always_comb begin
    gnt_oh   = '0;
    gnt_data = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (gnt_any && (gnt_idx == SelWidth'(i))) begin
        gnt_oh[i] = 1'b1;
        gnt_data  = d[i*Width +: Width];
      end
    end
  end

  // Only the winner is released, and only when the slot can load; reset holds off everyone
  assign d_bp = ~(gnt_oh & {NumInputs{load & ~reset}});

  // Slot and pointer next state
  always_comb begin
    q_d     = q_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (gnt_any) begin
        q_d     = gnt_data;
        src_d   = gnt_idx;
        valid_d = 1'b1;
        // The pointer moves only when a packet completes
        if (gnt_last) begin
          ptr_d = wrap_add(gnt_idx, 32'd1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Slot and pointer registers; reset discards any token in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      q_q     <= q_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q       = q_q;
  assign q_src   = src_q;
  assign q_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/li_rr_merge.md
Name: li_rr_merge

Overview:
- N-to-1 latency-insensitive merge stage that sits directly upstream of the pipeline registers and latches.
- Arbitrates round-robin among NumInputs valid/bp channels and captures the winner in one registered output slot.
- Its output port pair (q, q_valid, q_bp) plugs straight into a pipeline register or latch input.
- Sustains one token per cycle when downstream does not backpressure.

Parameters:
- Width, 8, data bits per channel.
- NumInputs, 2, number of input channels; legal range 2..16.
- SelWidth, 1, width of the source index; must satisfy 2^SelWidth >= NumInputs.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- d  input  NumInputs*Width  concatenated input data; channel i occupies bits [i*Width +: Width].
- d_valid  input  NumInputs  per-channel valid.
- d_bp  output  NumInputs  per-channel backpressure; 1 means the token is not taken this cycle.
- q  output  Width  registered output data.
- q_src  output  SelWidth  index of the channel that produced q.
- q_valid  output  1  output slot holds a token.
- q_bp  input  1  downstream backpressure.
- d_last  input  NumInputs  end-of-packet marker per channel; present only when RR_MERGE_LOCK_EN is defined.

Behaviour:
- Reset (clk edge with reset=1):
  - q_valid=0, q=0, q_src=0.
  - Priority pointer ptr=0; lock state cleared.
  - Reset overrides any in-flight token, which is dropped.
  - During reset cycles d_bp is all-ones.
- Handshakes:
  - outgoing = q_valid & ~q_bp.
  - load = ~q_valid | ~q_bp: the slot can accept when it is empty or is emptying this cycle.
- Grant (combinational):
  - Scan channels ptr, ptr+1, ... wrapping modulo NumInputs.
  - grant = first channel i with d_valid[i]=1; none if all valid bits are 0.
- Backpressure: d_bp[i] = ~(load & grant==i). Every non-granted channel sees bp=1, even when it is valid.
- Clock edge with load=1 and a grant g:
  - q <= d[g]; q_src <= g; q_valid <= 1.
  - ptr <= (g+1) mod NumInputs.
- Clock edge with load=1 and no grant: q_valid <= 0 (the slot drains if outgoing); q, q_src and ptr hold.
- Clock edge with load=0: all state holds. The token stays stable while q_bp=1.
- Latency: a token accepted in cycle t appears on q with q_valid=1 in cycle t+1.
- Throughput: 1 token/cycle with q_bp=0 continuously.
- Simultaneous outgoing and incoming in the same cycle: the slot is replaced with no bubble.
- Fairness: a continuously valid channel is granted within NumInputs accepted tokens.
- Pointer wrap: g=NumInputs-1 sends ptr to 0.
- Combinational paths:
  - q_bp to d_bp: permitted.
  - d_valid to d_bp: permitted through the grant logic.
  - d to q: not permitted (registered only).
- Input stability: inputs may change d_valid/d only after a cycle with d_bp=0. The block does not depend on this.

Optional Feature:
- Macro: RR_MERGE_LOCK_EN.
- Defined:
  - Adds the d_last port and a lock register plus a locked-channel register.
  - When a token from channel g is accepted with d_last[g]=0, lock <= 1 and locked-channel <= g.
  - While locked, grant considers only the locked channel; other valid channels stay backpressured even if the locked channel is idle.
  - Lock clears when the locked channel's token is accepted with d_last=1.
  - ptr advances only when that last token is accepted.
  - Reset clears the lock.
- Undefined: no d_last port; every token is treated as last; behaviour is exactly as above.

Test Plan:
- Reset, then one token: reset held 2 cycles, then d_valid=01, d[0]=0xA5, q_bp=0. Required:
  - q_valid=0 during reset.
  - d_bp[0]=0 in the accept cycle.
  - Next cycle q=0xA5, q_src=0, q_valid=1.
- Round-robin fairness: NumInputs=4, all channels valid continuously with data 0x10..0x13, q_bp=0 for 8 cycles. Required:
  - q_src sequence 0,1,2,3,0,1,2,3.
  - One token per cycle, no bubbles.
- Backpressure stall: token 0x3C in the slot, q_bp=1 for 3 cycles while channel 1 is valid. Required:
  - q holds 0x3C and q_valid stays 1.
  - d_bp=all-ones.
  - When q_bp drops, channel 1's token loads in the same cycle; the next cycle shows q_src=1.
- Drain and wrap: ptr=NumInputs-1, only channel NumInputs-1 valid once, then no valid inputs. Required:
  - Token output, then q_valid=0.
  - ptr=0 afterwards, so with channels 0 and 1 valid next, channel 0 wins.
- Reset mid-stream: reset=1 while q_valid=1 and q_bp=1. Required:
  - Next cycle q_valid=0, q_src=0, ptr=0.
  - The held token is never emitted.
- Lock (RR_MERGE_LOCK_EN): channel 0 sends a 3-token packet (d_last=0,0,1) while channel 1 is valid throughout. Required:
  - q_src sequence 0,0,0,1.
  - d_bp[1]=1 until channel 0's last token is accepted.
